// File: rtl/shared_pkg.sv
// Shared definitions for the synchronous FIFO and its read-side stream master.
// Holds the data width, FIFO depth, the read-buffer occupancy encoding and
// the depth of the read-side output buffer.
package shared_pkg;

    localparam int FIFO_WIDTH   = 16;
    localparam int FIFO_DEPTH   = 16;
    localparam int RD_BUF_DEPTH = 2;

    // Occupancy of the read-side output buffer; encodings equal the word count.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } rd_occ_e;

    // Number of buffered words represented by an occupancy state.
    function automatic logic [1:0] occ_to_cnt(input rd_occ_e occ);
        return 2'(occ);
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port, the downstream valid/ready stream and the
// status outputs of fifo_rd_stream. The master modport is the read-side
// block itself; the slave modport is the FIFO plus consumer around it.
interface fifo_rd_stream_if #(
    parameter int WIDTH = shared_pkg::FIFO_WIDTH
) ();

    // FIFO side
    logic             empty;
    logic             underflow;
    logic [WIDTH-1:0] data_out;
    logic             rd_en;
    // control
    logic             flush;
    // stream side
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    // status
    logic             busy;
    logic             err_underflow;

    modport master (
        input  empty, underflow, data_out, flush, m_ready,
        output rd_en, m_data, m_valid, busy, err_underflow
    );

    modport slave (
        output empty, underflow, data_out, flush, m_ready,
        input  rd_en, m_data, m_valid, busy, err_underflow
    );

endinterface

// File: rtl/fifo_rd_skid.sv
// Two-entry circular output buffer for fifo_rd_stream. Words are written at
// wr_ptr on push and presented from rd_ptr; both 1-bit pointers wrap at 2.
// The caller guarantees no push into a full buffer without a same-cycle pop,
// so the head entry never changes while it is being presented.
module fifo_rd_skid #(
    parameter int WIDTH = shared_pkg::FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);
    import shared_pkg::*;

    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [WIDTH-1:0] w_entry [RD_BUF_DEPTH];

    // Pointer update; flush returns both pointers to slot 0 like reset.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            if (i_push) r_wr_ptr <= !r_wr_ptr;
            if (i_pop)  r_rd_ptr <= !r_rd_ptr;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < RD_BUF_DEPTH; gi++) begin : g_entry
            localparam logic SLOT = 1'(gi);
            logic [WIDTH-1:0] r_word;

            // Storage slot: captures data on a push aimed at this slot; a
            // capture coinciding with flush is dropped.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_word <= '0;
                end else if (i_push && !i_flush && (r_wr_ptr == SLOT)) begin
                    r_word <= i_data;
                end
            end

            assign w_entry[gi] = r_word;
        end
    endgenerate

    assign o_data = w_entry[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side master for the synchronous FIFO: issues rd_en against a 2-word
// credit, captures data_out one cycle later into fifo_rd_skid and presents it
// as a full-throughput valid/ready stream.
// Optional feature macro: FIFO_RD_STATS_EN adds saturating rd_count and
// stall_count ports; without it those ports and counters do not exist.
module fifo_rd_stream #(
    parameter int FIFO_WIDTH = shared_pkg::FIFO_WIDTH,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    fifo_rd_stream_if.master bus
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] stall_count
`endif
);
    import shared_pkg::*;

    rd_occ_e         r_occ;
    logic            r_inflight;
    logic            r_err;

    logic            w_valid;
    logic            w_pop;
    logic            w_push;
    logic            w_rd_en;
    logic [2:0]      w_credit_sum;
    logic [FIFO_WIDTH-1:0] w_skid_data;

    assign w_valid = (r_occ != OCC_EMPTY);
    assign w_pop   = w_valid && bus.m_ready;
    assign w_push  = r_inflight;

    // Words that will be held after this edge if a read is not issued now.
    // Depending on m_ready here is what lets a pop free a slot in the same
    // cycle and keep the stream at one word per cycle.
    assign w_credit_sum = {1'b0, occ_to_cnt(r_occ)} + {2'b00, r_inflight}
                        - {2'b00, w_pop};
    assign w_rd_en = !rst && !bus.flush && !bus.empty && (w_credit_sum < 3'd2);

    // Occupancy FSM plus the in-flight read flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occ      <= OCC_EMPTY;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (bus.flush) begin
                r_occ <= OCC_EMPTY;
            end else begin
                case (r_occ)
                    OCC_EMPTY: if (w_push) r_occ <= OCC_ONE;
                    OCC_ONE: begin
                        if (w_push && !w_pop)      r_occ <= OCC_TWO;
                        else if (w_pop && !w_push) r_occ <= OCC_EMPTY;
                    end
                    OCC_TWO:   if (w_pop && !w_push) r_occ <= OCC_ONE;
                    default:   r_occ <= OCC_EMPTY;
                endcase
            end
        end
    end

    // Sticky protocol-violation flag: the FIFO flagged underflow for a read
    // this block issued on the previous cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_inflight && bus.underflow) begin
            r_err <= 1'b1;
        end
    end

    fifo_rd_skid #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.flush),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (bus.data_out),
        .o_data  (w_skid_data)
    );

    assign bus.rd_en         = w_rd_en;
    assign bus.m_valid       = w_valid;
    assign bus.m_data        = w_skid_data;
    assign bus.busy          = w_valid || r_inflight;
    assign bus.err_underflow = r_err;

`ifdef FIFO_RD_STATS_EN
    logic [CNT_W-1:0] r_rd_count;
    logic [CNT_W-1:0] r_stall_count;

    // Saturating counters of accepted reads and backpressured stream cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_rd_en && !bus.empty && (r_rd_count != '1))
                r_rd_count <= r_rd_count + 1'b1;
            if (w_valid && !bus.m_ready && (r_stall_count != '1))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign rd_count    = r_rd_count;
    assign stall_count = r_stall_count;
`endif

endmodule
